mux_n_reg: RTL and testbench



---
 rtl/mux_pkg.sv | 26 ++
 rtl/mux_n_reg_rr_arbiter.sv | 45 ++++
 rtl/mux_n_reg.sv | 123 ++++++++++++
 tb/tb_mux_n_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Purpose : Shared mode constants, output-stage state type and selector-width
//           helper for the N-channel registered selector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // At least one bit so a selector port always exists, even for N=1.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_reg_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter; scans from last+1 with wrap and
//           returns a one-hot grant, its index and an any-grant flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] idx_o,
    output logic          any_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        // Offset N wraps back to last itself, so it has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = SW'(cand);
            end
        end
    end

    assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/mux_n_reg.sv
// ============================================================================
// Module  : mux_n_reg
// Purpose : N:1 selector with registered valid/ready output stage; fixed or
//           round-robin selection. Optional out_sel tag via MUX_SEL_TAG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_reg
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SW    = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_SEL_TAG_EN
    ,
    output logic [SW-1:0]      out_sel
`endif
);

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    last_q, last_d;

    logic [N-1:0]     w_rr_grant;
    logic [SW-1:0]    w_rr_idx;
    logic             w_rr_any;
    logic [N-1:0]     w_fix_grant;
    logic             w_fix_valid;
    logic [N-1:0]     w_grant;
    logic [SW-1:0]    w_g;
    logic             w_grant_valid;
    logic             w_load;
    logic [WIDTH-1:0] w_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req_i   (in_valid),
        .last_i  (last_q),
        .grant_o (w_rr_grant),
        .idx_o   (w_rr_idx),
        .any_o   (w_rr_any)
    );

    // An out-of-range selector decodes to no channel at all.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) w_fix_grant[i] = 1'b1;
        end
    end
    assign w_fix_valid = |(w_fix_grant & in_valid);

    assign w_grant       = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    assign w_g           = (mode == MODE_RR) ? w_rr_idx   : sel;
    assign w_grant_valid = (mode == MODE_RR) ? w_rr_any   : w_fix_valid;

    // Reset gates load so no channel sees a handshake in the reset cycle.
    assign w_load   = !rst && w_grant_valid && ((state_q == ST_EMPTY) || out_ready);
    assign in_ready = w_load ? w_grant : '0;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) w_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        if (w_load) begin
            state_d = ST_FULL;
            data_d  = w_data;
            if (mode == MODE_RR) last_d = w_g;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            last_q  <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifdef MUX_SEL_TAG_EN
    logic [SW-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst)         tag_q <= '0;
        else if (w_load) tag_q <= w_g;
    end

    assign out_sel = tag_q;
`endif

    assign out_data  = data_q;
    assign out_valid = (state_q == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_mux_n_reg.sv
// ============================================================================
// Module  : tb_mux_n_reg
// Purpose : Directed self-checking bench for mux_n_reg (N=4 and N=3 builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_n_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3, out_ready3;

`ifdef MUX_SEL_TAG_EN
    logic [1:0]  out_sel, out_sel3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_SEL_TAG_EN
        ,
        .out_sel   (out_sel)
`endif
    );

    mux_n_reg #(.N(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (1'b0),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef MUX_SEL_TAG_EN
        ,
        .out_sel   (out_sel3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every channel requesting.
        rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'hF; in_data = 32'h13121110;
        sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b111; in_data3 = 24'h323130;
        #1;
        check("rst_in_ready_pre", in_ready, 4'b0000);
        check("rst_in_ready3_pre", in_ready3, 3'b000);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 8'h00);
            check("rst_in_ready", in_ready, 4'b0000);
        end
        rst = 1'b0; in_valid = 4'h0; in_valid3 = 3'b000;

        // Fixed mode, sel=2.
        sel = 2'd2; in_data = 32'h00A50000; in_valid = 4'b0100;
        #1 check("fix_in_ready", in_ready, 4'b0100);
        tick();
        check("fix_out_data", out_data, 8'hA5);
        check("fix_out_valid", out_valid, 1'b1);
`ifdef MUX_SEL_TAG_EN
        check("fix_out_sel", out_sel, 2'd2);
`endif

        // Backpressure holds the word; releasing it loads the next one the same cycle.
        out_ready = 1'b0; in_data = 32'h005A0000;
        #1 check("bp_in_ready", in_ready, 4'b0000);
        tick();
        check("bp_hold_data", out_data, 8'hA5);
        check("bp_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        #1 check("b2b_in_ready", in_ready, 4'b0100);
        tick();
        check("b2b_out_data", out_data, 8'h5A);
        check("b2b_out_valid", out_valid, 1'b1);

        // Nothing valid: output drains.
        in_valid = 4'h0;
        #1 check("idle_in_ready", in_ready, 4'b0000);
        tick();
        check("drain_out_valid", out_valid, 1'b0);

        // Round robin over all channels, starting at ch0 (pointer reset to 3).
        mode = 1'b1; in_valid = 4'hF; in_data = 32'h13121110;
        for (int k = 0; k < 7; k++) begin
            #1 check("rr_in_ready", in_ready, 4'b0001 << (k % 4));
            tick();
            check("rr_out_data", out_data, 8'h10 + 8'(k % 4));
            check("rr_out_valid", out_valid, 1'b1);
        end

        // Pointer now 2: only ch1 valid wraps through 3,0 to ch1.
        in_valid = 4'b0010;
        #1 check("wrap_in_ready", in_ready, 4'b0010);
        tick();
        check("wrap_out_data", out_data, 8'h11);
`ifdef MUX_SEL_TAG_EN
        check("wrap_out_sel", out_sel, 2'd1);
`endif
        in_valid = 4'b1010;
        #1 check("skip_in_ready", in_ready, 4'b1000);
        tick();
        check("skip_out_data", out_data, 8'h13);

        // Mode switch while FULL and stalled leaves the held word alone.
        out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
        in_valid = 4'b0001; in_data = 32'h13121177;
        #1 check("msw_in_ready", in_ready, 4'b0000);
        tick();
        check("msw_hold_data", out_data, 8'h13);
        check("msw_hold_valid", out_valid, 1'b1);
`ifdef MUX_SEL_TAG_EN
        check("msw_hold_sel", out_sel, 2'd3);
`endif
        out_ready = 1'b1;
        #1 check("msw_load_ready", in_ready, 4'b0001);
        tick();
        check("msw_out_data", out_data, 8'h77);
`ifdef MUX_SEL_TAG_EN
        check("msw_out_sel", out_sel, 2'd0);
`endif

        // Fixed-mode load must not have moved the pointer from 3: RR picks ch0.
        mode = 1'b1; in_valid = 4'hF;
        #1 check("ptr_kept_in_ready", in_ready, 4'b0001);
        tick();
        check("ptr_kept_data", out_data, 8'h77);

        // N=3 instance: sel=3 is out of range.
        sel3 = 2'd3; in_valid3 = 3'b111;
        #1 check("n3_oor_in_ready", in_ready3, 3'b000);
        tick();
        check("n3_oor_out_valid", out_valid3, 1'b0);
        sel3 = 2'd2;
        #1 check("n3_sel2_in_ready", in_ready3, 3'b100);
        tick();
        check("n3_sel2_out_data", out_data3, 8'h32);
`ifdef MUX_SEL_TAG_EN
        check("n3_sel2_out_sel", out_sel3, 2'd2);
`endif
        sel3 = 2'd3;
        #1 check("n3_oor2_in_ready", in_ready3, 3'b000);
        tick();
        check("n3_oor2_out_data", out_data3, 8'h32);
        check("n3_oor2_out_valid", out_valid3, 1'b0);

        // Reset while FULL discards the word and gates in_ready.
        out_ready = 1'b0; rst = 1'b1;
        #1 check("midrst_in_ready", in_ready, 4'b0000);
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
`ifdef MUX_SEL_TAG_EN
        check("midrst_out_sel", out_sel, 2'd0);
`endif
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
